// File: rtl/trigger_led_pkg.sv
// Shared types and elaboration helpers for the multi-channel trigger LED bank.
`timescale 1ns/1ps
package trigger_led_pkg;

  typedef enum logic [1:0] {
    MODE_RETRIG  = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_LATCH   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_LATCHED = 2'd2
  } state_e;

  // True when a CNT_W-bit counter can hold the value HOLD_CYCLES.
  function automatic bit cnt_width_ok(input int unsigned cnt_w, input longint unsigned hold);
    longint unsigned one;
    one = 64'd1;
    if (cnt_w >= 32'd63) return 1'b1;
    return (one << cnt_w) > hold;
  endfunction

endpackage

// File: rtl/trigger_led_channel.sv
// One trigger/LED channel: synchroniser, rising-edge detect, mode FSM, hold and blink counters.
`timescale 1ns/1ps
module trigger_led_channel
  import trigger_led_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1_000_000,
  parameter int unsigned BLINK_HALF  = 250_000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  trigger_i,
  input  mode_e mode_i,
  input  logic  clear_i,
  output logic  led_o,
  output logic  busy_o,
  output logic  missed_o
);

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_HALF - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   arm_q;
  logic                   rise;

  // arm_q keeps edge detection off until both the synchroniser and prev_q
  // hold real post-reset samples, so a trigger held high through reset is not an edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & arm_q[SYNC_STAGES];

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             missed_q, missed_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_RETRIG;
      cnt_q    <= '0;
      phase_q  <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    led_d    = led_q;
    busy_d   = busy_q;
    missed_d = missed_q;
    if (clear_i) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      phase_d  = '0;
      led_d    = 1'b0;
      busy_d   = 1'b0;
      missed_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            mode_d  = mode_i;
            cnt_d   = HOLD_LOAD;
            phase_d = BLINK_LOAD;
            led_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = (mode_i == MODE_LATCH) ? ST_LATCHED : ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // A retrigger reload takes precedence over expiry in the same cycle.
          if (rise && mode_q == MODE_RETRIG) begin
            cnt_d = HOLD_LOAD;
            led_d = 1'b1;
          end else begin
            if (rise) missed_d = 1'b1;
            if (cnt_q == '0) begin
              state_d = ST_IDLE;
              led_d   = 1'b0;
              busy_d  = 1'b0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
              if (mode_q == MODE_BLINK) begin
                if (phase_q == '0) begin
                  led_d   = ~led_q;
                  phase_d = BLINK_LOAD;
                end else begin
                  phase_d = phase_q - CNT_W'(1);
                end
              end
            end
          end
        end
        ST_LATCHED: begin
          if (rise) missed_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign led_o    = led_q;
  assign busy_o   = busy_q;
  assign missed_o = missed_q;

endmodule

// File: rtl/trigger_led_bank.sv
// Multi-channel LED pulse stretcher: parameter checks and one trigger_led_channel per trigger input.
`timescale 1ns/1ps
module trigger_led_bank
  import trigger_led_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned HOLD_CYCLES = 1_000_000,
  parameter int unsigned BLINK_HALF  = 250_000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trigger,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] missed
);

  if (!cnt_width_ok(CNT_W, longint'(HOLD_CYCLES))) begin : g_bad_cnt_w
    $error("trigger_led_bank: CNT_W too small for HOLD_CYCLES");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("trigger_led_bank: CHANNELS must be 1..16");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("trigger_led_bank: HOLD_CYCLES must be >= 2");
  end
  if (BLINK_HALF < 1 || BLINK_HALF >= HOLD_CYCLES) begin : g_bad_blink
    $error("trigger_led_bank: BLINK_HALF must be >= 1 and < HOLD_CYCLES");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("trigger_led_bank: SYNC_STAGES must be >= 2");
  end

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    trigger_led_channel #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .BLINK_HALF  (BLINK_HALF),
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .trigger_i (trigger[ch]),
      .mode_i    (mode_s),
      .clear_i   (clear[ch]),
      .led_o     (led[ch]),
      .busy_o    (busy[ch]),
      .missed_o  (missed[ch])
    );
  end

endmodule
